// File: rtl/regfile_2r1w.sv
`default_nettype none
// ============================================================================
// Module   : regfile_2r1w
// Brief    : Flip-flop register file, one write port, two combinational read
//            ports, synchronous clear, optional $zero entry and write-through.
// Revision : 1.0
// ============================================================================
module regfile_2r1w #(
    parameter int WIDTH         = 32,
    parameter int DEPTH         = 32,
    parameter int ADDR_W        = 5,
    parameter int ZERO_REG      = 1,
    parameter int WRITE_THROUGH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [WIDTH-1:0]  rdata0,
    output logic [WIDTH-1:0]  rdata1
);

    logic [WIDTH-1:0] r_mem_q [DEPTH];
    logic [WIDTH-1:0] w_mem_d [DEPTH];

    // Out-of-range write addresses match no entry, so they drop silently.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_mem_d[i] = r_mem_q[i];
            if (we && (waddr == ADDR_W'(i)) && !((ZERO_REG != 0) && (i == 0))) begin
                w_mem_d[i] = wdata;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_mem_q[gi] <= '0;
                end else begin
                    r_mem_q[gi] <= w_mem_d[gi];
                end
            end
        end
    endgenerate

    function automatic logic [WIDTH-1:0] f_read(
        input logic [ADDR_W-1:0] addr,
        input logic [WIDTH-1:0]  mem [DEPTH],
        input logic              rst_i,
        input logic              we_i,
        input logic [ADDR_W-1:0] waddr_i,
        input logic [WIDTH-1:0]  wdata_i
    );
        logic [WIDTH-1:0] stored;
        logic             hit;
        stored = '0;
        hit    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr == ADDR_W'(i)) begin
                stored = mem[i];
                hit    = 1'b1;
            end
        end
        // The zero entry outranks forwarding; forwarding is gated by reset.
        if ((ZERO_REG != 0) && (addr == '0)) begin
            f_read = '0;
        end else if ((WRITE_THROUGH != 0) && !rst_i && we_i && hit && (waddr_i == addr)) begin
            f_read = wdata_i;
        end else begin
            f_read = stored;
        end
    endfunction

    always_comb begin
        rdata0 = f_read(raddr0, r_mem_q, rst, we, waddr, wdata);
    end

    always_comb begin
        rdata1 = f_read(raddr1, r_mem_q, rst, we, waddr, wdata);
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_2r1w.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_2r1w
// Brief    : Directed bench driving three builds (default, plain-zero/no-
//            forward, 20-deep) with shared stimulus and fixed expectations.
// Revision : 1.0
// ============================================================================
module tb_regfile_2r1w;

    logic        clk = 1'b0;
    logic        rst, we;
    logic [4:0]  waddr, raddr0, raddr1;
    logic [31:0] wdata;
    logic [31:0] rd0_a, rd1_a, rd0_b, rd1_b, rd0_c, rd1_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_2r1w u_dut_a (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr0(raddr0), .raddr1(raddr1), .rdata0(rd0_a), .rdata1(rd1_a)
    );

    regfile_2r1w #(.ZERO_REG(0), .WRITE_THROUGH(0)) u_dut_b (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr0(raddr0), .raddr1(raddr1), .rdata0(rd0_b), .rdata1(rd1_b)
    );

    regfile_2r1w #(.DEPTH(20), .ADDR_W(5)) u_dut_c (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr0(raddr0), .raddr1(raddr1), .rdata0(rd0_c), .rdata1(rd1_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr0 = '0; raddr1 = '0;
        #2;
        tick();
        rst = 1'b0;

        // Reset state at every address
        for (int a = 0; a < 32; a++) begin
            raddr0 = 5'(a); raddr1 = 5'(31 - a);
            #1;
            check("rst_a_p0", rd0_a, 32'h0);
            check("rst_a_p1", rd1_a, 32'h0);
            check("rst_b_p0", rd0_b, 32'h0);
        end

        // Fill 1..31 then clear
        for (int a = 1; a < 32; a++) begin
            we = 1'b1; waddr = 5'(a); wdata = 32'hDEADBEEF;
            tick();
        end
        we = 1'b0; raddr0 = 5'd5; raddr1 = 5'd25;
        #1;
        check("fill_a_5", rd0_a, 32'hDEADBEEF);
        check("fill_b_25", rd1_b, 32'hDEADBEEF);
        check("fill_c_25_oor", rd1_c, 32'h0);
        raddr0 = 5'd0;
        #1;
        check("fill_b_0", rd0_b, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int a = 0; a < 32; a++) begin
            raddr0 = 5'(a); raddr1 = 5'(a);
            #1;
            check("clr_a_p0", rd0_a, 32'h0);
            check("clr_a_p1", rd1_a, 32'h0);
            check("clr_b_p0", rd0_b, 32'h0);
            check("clr_c_p1", rd1_c, 32'h0);
        end

        // Basic write/read, then disabled write
        we = 1'b1; waddr = 5'd5; wdata = 32'h3;
        tick();
        we = 1'b0; raddr0 = 5'd5; raddr1 = 5'd5;
        #1;
        check("wr_a_p0", rd0_a, 32'h3);
        check("wr_a_p1", rd1_a, 32'h3);
        check("wr_b_p1", rd1_b, 32'h3);
        check("wr_c_p0", rd0_c, 32'h3);
        wdata = 32'h5;
        #1;
        check("we0_fwd_a", rd0_a, 32'h3);
        tick();
        check("we0_a", rd0_a, 32'h3);
        check("we0_b", rd0_b, 32'h3);

        // Zero register
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr0 = 5'd0;
        #1;
        check("zero_pre_a", rd0_a, 32'h0);
        check("zero_pre_b", rd0_b, 32'h0);
        tick();
        we = 1'b0;
        #1;
        check("zero_post_a", rd0_a, 32'h0);
        check("zero_post_b", rd0_b, 32'hFFFFFFFF);
        check("zero_post_c", rd0_c, 32'h0);

        // Forwarding
        we = 1'b1; waddr = 5'd7; wdata = 32'h11111111;
        tick();
        wdata = 32'h22222222; raddr0 = 5'd7; raddr1 = 5'd7;
        #1;
        check("fwd_pre_a_p0", rd0_a, 32'h22222222);
        check("fwd_pre_a_p1", rd1_a, 32'h22222222);
        check("fwd_pre_b_p0", rd0_b, 32'h11111111);
        check("fwd_pre_b_p1", rd1_b, 32'h11111111);
        tick();
        we = 1'b0;
        #1;
        check("fwd_post_a", rd0_a, 32'h22222222);
        check("fwd_post_b", rd1_b, 32'h22222222);

        // Reset beats write
        we = 1'b1; waddr = 5'd9; wdata = 32'h5;
        tick();
        rst = 1'b1; wdata = 32'hA5A5A5A5; raddr0 = 5'd9;
        #1;
        check("rstw_pre_a", rd0_a, 32'h5);
        check("rstw_pre_b", rd0_b, 32'h5);
        tick();
        rst = 1'b0; we = 1'b0;
        #1;
        check("rstw_post_a", rd0_a, 32'h0);
        check("rstw_post_c", rd0_c, 32'h0);
        raddr1 = 5'd7;
        #1;
        check("rstw_clr7_b", rd1_b, 32'h0);
        we = 1'b1;
        tick();
        we = 1'b0;
        #1;
        check("after_rst_a", rd0_a, 32'hA5A5A5A5);
        check("after_rst_b", rd0_b, 32'hA5A5A5A5);

        // Non-power-of-two depth
        we = 1'b1; waddr = 5'd25; wdata = 32'h12345678; raddr0 = 5'd25;
        #1;
        check("np_pre_c", rd0_c, 32'h0);
        check("np_pre_a", rd0_a, 32'h12345678);
        tick();
        we = 1'b0;
        #1;
        check("np_post_c", rd0_c, 32'h0);
        check("np_post_a", rd0_a, 32'h12345678);
        for (int a = 0; a < 20; a++) begin
            raddr0 = 5'(a);
            #1;
            check("np_keep_c", rd0_c, (a == 9) ? 32'hA5A5A5A5 : 32'h0);
        end
        we = 1'b1; waddr = 5'd19; wdata = 32'hCAFEF00D;
        tick();
        we = 1'b0; raddr0 = 5'd19; raddr1 = 5'd20;
        #1;
        check("np_19_c", rd0_c, 32'hCAFEF00D);
        check("np_20_c", rd1_c, 32'h0);
        check("np_20_a", rd1_a, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
